// File: rtl/instr_overlay.sv
// Instruction-panel overlay: windows the raster into ROM coordinates and colour-key composites the panel over the scene.
// Optional blink of the steady panel is enabled by defining INSTR_OVERLAY_BLINK_EN.
module instr_overlay #(
    parameter int          ORIGIN_X    = 201,
    parameter int          ORIGIN_Y    = 400,
    parameter int          IMG_W       = 237,
    parameter int          IMG_H       = 21,
    parameter int          HOLD_FRAMES = 60,
    parameter logic [7:0]  TRANSPARENT = 8'hE3
) (
    input  logic       vga_clk,
    input  logic       rst_n,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    input  logic       blank,
    input  logic       frame_start,
    input  logic       show_req,
    input  logic       instr_sel,
    input  logic [7:0] bg_pixel,
    output logic [7:0] x_pos,
    output logic [4:0] y_pos,
    output logic       instr_type,
    input  logic [7:0] mem_data,
    output logic [7:0] pix_out,
    output logic       pix_blank
);

    localparam int HCW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

    localparam logic [10:0] X_LO = 11'(ORIGIN_X);
    localparam logic [10:0] X_HI = 11'(ORIGIN_X + IMG_W);
    localparam logic [10:0] Y_LO = 11'(ORIGIN_Y);
    localparam logic [10:0] Y_HI = 11'(ORIGIN_Y + IMG_H);
    localparam logic [9:0]  OX   = 10'(ORIGIN_X);
    localparam logic [9:0]  OY   = 10'(ORIGIN_Y);

    typedef enum logic [1:0] {
        S_HIDDEN  = 2'd0,
        S_HOLD    = 2'd1,
        S_VISIBLE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
    logic           page_q, page_d;
    logic           vis;

    function automatic logic [7:0] composite(input logic       win,
                                             input logic [7:0] rom,
                                             input logic [7:0] bg,
                                             input logic       blk);
        if (blk)
            return 8'd0;
        if (win && rom != TRANSPARENT)
            return rom;
        return bg;
    endfunction

`ifdef INSTR_OVERLAY_BLINK_EN
    logic [4:0] blink_cnt_q, blink_cnt_d;
`endif

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_HIDDEN;
            hold_cnt_q  <= '0;
            page_q      <= 1'b0;
`ifdef INSTR_OVERLAY_BLINK_EN
            blink_cnt_q <= 5'd0;
`endif
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            page_q      <= page_d;
`ifdef INSTR_OVERLAY_BLINK_EN
            blink_cnt_q <= blink_cnt_d;
`endif
        end
    end

    // Panel state only moves on frame_start so a frame is never torn.
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        page_d      = page_q;
`ifdef INSTR_OVERLAY_BLINK_EN
        blink_cnt_d = blink_cnt_q;
`endif
        if (frame_start) begin
            case (state_q)
                S_HIDDEN: begin
                    if (show_req) begin
                        state_d    = S_HOLD;
                        hold_cnt_d = HCW'(HOLD_FRAMES - 1);
                        page_d     = instr_sel;
                    end
                end
                S_HOLD: begin
                    if (hold_cnt_q != '0) begin
                        hold_cnt_d = hold_cnt_q - 1'b1;
                        page_d     = instr_sel;
                    end else if (show_req) begin
                        state_d     = S_VISIBLE;
`ifdef INSTR_OVERLAY_BLINK_EN
                        blink_cnt_d = 5'd0;
`endif
                    end else begin
                        state_d = S_HIDDEN;
                    end
                end
                S_VISIBLE: begin
                    if (!show_req) begin
                        state_d = S_HIDDEN;
                    end else begin
                        page_d      = instr_sel;
`ifdef INSTR_OVERLAY_BLINK_EN
                        blink_cnt_d = blink_cnt_q + 5'd1;
`endif
                    end
                end
                default: state_d = S_HIDDEN;
            endcase
        end
    end

`ifdef INSTR_OVERLAY_BLINK_EN
    assign vis = (state_q == S_HOLD) || ((state_q == S_VISIBLE) && !blink_cnt_q[4]);
`else
    assign vis = (state_q != S_HIDDEN);
`endif

    logic       in_win;
    logic [7:0] x_nxt;
    logic [4:0] y_nxt;

    always_comb begin
        in_win = vis && !blank
                 && ({1'b0, hcount} >= X_LO) && ({1'b0, hcount} < X_HI)
                 && ({1'b0, vcount} >= Y_LO) && ({1'b0, vcount} < Y_HI);
        x_nxt  = in_win ? 8'(hcount - OX) : 8'd0;
        y_nxt  = in_win ? 5'(vcount - OY) : 5'd0;
    end

    logic       in_win_p1, blank_p1;
    logic [7:0] bg_p1;
    logic       in_win_p2, blank_p2;
    logic [7:0] bg_p2;

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            x_pos      <= 8'd0;
            y_pos      <= 5'd0;
            instr_type <= 1'b0;
            in_win_p1  <= 1'b0;
            bg_p1      <= 8'd0;
            blank_p1   <= 1'b0;
            in_win_p2  <= 1'b0;
            bg_p2      <= 8'd0;
            blank_p2   <= 1'b0;
            pix_out    <= 8'd0;
            pix_blank  <= 1'b0;
        end else begin
            // Stage 1: ROM address and raster side-band
            x_pos      <= x_nxt;
            y_pos      <= y_nxt;
            instr_type <= page_q;
            in_win_p1  <= in_win;
            bg_p1      <= bg_pixel;
            blank_p1   <= blank;
            // Stage 2: side-band waits while the ROM produces mem_data
            in_win_p2  <= in_win_p1;
            bg_p2      <= bg_p1;
            blank_p2   <= blank_p1;
            // Stage 3: composited output
            pix_out    <= composite(in_win_p2, mem_data, bg_p2, blank_p2);
            pix_blank  <= blank_p2;
        end
    end

endmodule

// File: tb/tb_instr_overlay.sv
// Directed bench for instr_overlay: windowing, colour key, latency, panel state machine and reset.
module tb_instr_overlay;

    logic       vga_clk;
    logic       rst_n;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       blank;
    logic       frame_start;
    logic       show_req;
    logic       instr_sel;
    logic [7:0] bg_pixel;
    logic [7:0] x_pos;
    logic [4:0] y_pos;
    logic       instr_type;
    logic [7:0] mem_data;
    logic [7:0] pix_out;
    logic       pix_blank;

    int n_chk  = 0;
    int n_pass = 0;

    instr_overlay #(
        .ORIGIN_X(201), .ORIGIN_Y(400), .IMG_W(237), .IMG_H(21),
        .HOLD_FRAMES(60), .TRANSPARENT(8'hE3)
    ) dut (
        .vga_clk(vga_clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount),
        .blank(blank), .frame_start(frame_start), .show_req(show_req),
        .instr_sel(instr_sel), .bg_pixel(bg_pixel), .x_pos(x_pos), .y_pos(y_pos),
        .instr_type(instr_type), .mem_data(mem_data), .pix_out(pix_out),
        .pix_blank(pix_blank)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic pulse_frame();
        hcount      = 10'd0;
        vcount      = 10'd0;
        blank       = 1'b1;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        step();
    endtask

    // Hold one raster position for three cycles: address checked after one, pixel after three.
    task automatic probe(input string tag, input int h, input int v, input logic blk,
                         input logic [7:0] bg, input logic [7:0] mem,
                         input logic [7:0] ex, input logic [4:0] ey, input logic et,
                         input logic [7:0] epix);
        hcount   = 10'(h);
        vcount   = 10'(v);
        blank    = blk;
        bg_pixel = bg;
        mem_data = mem;
        step();
        check({tag, ".x_pos"}, x_pos, ex);
        check({tag, ".y_pos"}, y_pos, ey);
        check({tag, ".instr_type"}, instr_type, et);
        step();
        step();
        check({tag, ".pix_out"}, pix_out, epix);
        check({tag, ".pix_blank"}, pix_blank, blk);
    endtask

    logic [7:0] bgs [10];
    logic       blks[10];

    initial begin
        rst_n = 1'b0; hcount = '0; vcount = '0; blank = 1'b0; frame_start = 1'b0;
        show_req = 1'b0; instr_sel = 1'b0; bg_pixel = 8'h77; mem_data = 8'h1C;
        step();
        step();
        check("rst.pix_out", pix_out, 8'h00);
        check("rst.pix_blank", pix_blank, 1'b0);
        check("rst.x_pos", x_pos, 8'h00);
        check("rst.y_pos", y_pos, 5'h00);
        check("rst.instr_type", instr_type, 1'b0);
        rst_n = 1'b1;
        step();

        // Hidden panel: output is the scene, delayed exactly three cycles.
        pulse_frame();
        pulse_frame();
        for (int i = 0; i < 10; i++) begin
            bgs[i]  = 8'(i * 29 + 3);
            blks[i] = (i == 6);
        end
        for (int i = 0; i < 10; i++) begin
            if (i >= 3) begin
                check("lat.pix_out", pix_out, blks[i-3] ? 8'h00 : bgs[i-3]);
                check("lat.pix_blank", pix_blank, blks[i-3]);
                check("lat.x_pos", x_pos, 8'h00);
            end
            hcount   = 10'd250;
            vcount   = 10'd410;
            blank    = blks[i];
            bg_pixel = bgs[i];
            mem_data = 8'h1C;
            step();
        end

        // Show page 1: enters HOLD.
        show_req  = 1'b1;
        instr_sel = 1'b1;
        pulse_frame();
        probe("corner_tl", 201, 400, 1'b0, 8'h55, 8'h1C, 8'd0,   5'd0,  1'b1, 8'h1C);
        probe("corner_br", 437, 420, 1'b0, 8'h55, 8'h1C, 8'd236, 5'd20, 1'b1, 8'h1C);
        probe("right_out", 438, 420, 1'b0, 8'h55, 8'h1C, 8'd0,   5'd0,  1'b1, 8'h55);
        probe("left_out",  200, 400, 1'b0, 8'h56, 8'h1C, 8'd0,   5'd0,  1'b1, 8'h56);
        probe("below_out", 201, 421, 1'b0, 8'h57, 8'h1C, 8'd0,   5'd0,  1'b1, 8'h57);
        probe("key",       300, 410, 1'b0, 8'h66, 8'hE3, 8'd99,  5'd10, 1'b1, 8'h66);
        probe("blank_win", 300, 410, 1'b1, 8'h66, 8'h1C, 8'd0,   5'd0,  1'b1, 8'h00);

        // Drop request: panel holds for the full 60 frames.
        show_req = 1'b0;
        repeat (59) pulse_frame();
        probe("hold_end",  210, 405, 1'b0, 8'h44, 8'h1C, 8'd9,   5'd5,  1'b1, 8'h1C);
        instr_sel = 1'b0;
        probe("sel_mid",   210, 405, 1'b0, 8'h44, 8'h1C, 8'd9,   5'd5,  1'b1, 8'h1C);
        pulse_frame();
        probe("hidden",    210, 405, 1'b0, 8'h44, 8'h1C, 8'd0,   5'd0,  1'b1, 8'h44);
        show_req = 1'b1;
        probe("req_mid",   210, 405, 1'b0, 8'h45, 8'h1C, 8'd0,   5'd0,  1'b1, 8'h45);

        // Re-show page 0, run through HOLD into VISIBLE, then switch to page 1.
        pulse_frame();
        probe("page0",     202, 401, 1'b0, 8'h33, 8'h1C, 8'd1,   5'd1,  1'b0, 8'h1C);
        repeat (60) pulse_frame();
        instr_sel = 1'b1;
        pulse_frame();
        probe("visible",   202, 401, 1'b0, 8'h33, 8'hA5, 8'd1,   5'd1,  1'b1, 8'hA5);
        show_req = 1'b0;
        pulse_frame();
        probe("vis_off",   202, 401, 1'b0, 8'h34, 8'hA5, 8'd0,   5'd0,  1'b1, 8'h34);
        show_req = 1'b1;
        pulse_frame();
        probe("reshow",    210, 405, 1'b0, 8'h22, 8'h1C, 8'd9,   5'd5,  1'b1, 8'h1C);

        // Asynchronous reset mid-line while the panel is up.
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.pix_out", pix_out, 8'h00);
        check("midrst.pix_blank", pix_blank, 1'b0);
        check("midrst.x_pos", x_pos, 8'h00);
        check("midrst.y_pos", y_pos, 5'h00);
        step();
        rst_n = 1'b1;
        probe("post_rst",  210, 405, 1'b0, 8'h22, 8'h1C, 8'd0,   5'd0,  1'b0, 8'h22);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
